fpu_dispatch: RTL and testbench

FPU_DISPATCH -- requirements
Module: fpu_dispatch

---
 rtl/fpu_dispatch_pkg.sv | 47 ++++
 rtl/fpu_op_check.sv | 22 ++
 rtl/fpu_dispatch.sv | 222 ++++++++++++++++++++++
 tb/tb_fpu_dispatch.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_dispatch_pkg.sv
// Shared definitions for the FP dispatch slice: FSM encoding, sfpu_op bit
// positions, rounding-mode codes and the legality helper.
package fpu_dispatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  localparam int OP_FADD     = 0;
  localparam int OP_FSUB     = 1;
  localparam int OP_FMUL     = 2;
  localparam int OP_FDIV     = 3;
  localparam int OP_FSQRT    = 4;
  localparam int OP_FMIN     = 5;
  localparam int OP_FMAX     = 6;
  localparam int OP_FMADD    = 7;
  localparam int OP_FMSUB    = 8;
  localparam int OP_FNMSUB   = 9;
  localparam int OP_FNMADD   = 10;
  localparam int OP_FSGNJ    = 11;
  localparam int OP_FSGNJN   = 12;
  localparam int OP_FSGNJX   = 13;
  localparam int OP_FEQ      = 14;
  localparam int OP_FLT      = 15;
  localparam int OP_FLE      = 16;
  localparam int OP_FCVT_F_I = 17;
  localparam int OP_FCVT_I_F = 18;
  localparam int OP_FMV_F_X  = 19;
  localparam int OP_FMV_X_F  = 20;
  localparam int OP_FCLASS   = 21;
  localparam int OP_UNSIGN   = 22;
  localparam int OP_SIGN     = 23;

  localparam logic [2:0] RM_DYN     = 3'b111;
  localparam logic [2:0] RM_RSV5    = 3'b101;
  localparam logic [2:0] RM_RSV6    = 3'b110;
  localparam logic [2:0] FPU_SEL_SP = 3'b001;

  // True when exactly one bit of the operation field is set.
  function automatic logic is_onehot22(input logic [21:0] v);
    return (v != 22'd0) && ((v & (v - 22'd1)) == 22'd0);
  endfunction

endpackage

// File: rtl/fpu_op_check.sv
// Combinational request screen: resolves the dynamic rounding mode and flags
// operations this dispatcher cannot issue.
module fpu_op_check
  import fpu_dispatch_pkg::*;
(
  input  logic [23:0] i_op,
  input  logic [2:0]  i_rm,
  input  logic [2:0]  i_frm,
  output logic [2:0]  o_rm,
  output logic        o_illegal
);

  logic [2:0] w_rm;

  assign w_rm = (i_rm == RM_DYN) ? i_frm : i_rm;
  assign o_rm = w_rm;

  // Modifier bits 22/23 take no part in the one-hot test.
  assign o_illegal = !is_onehot22(i_op[21:0]) || i_op[OP_FDIV] || i_op[OP_FSQRT] ||
                     (w_rm == RM_RSV5) || (w_rm == RM_RSV6);

endmodule

// File: rtl/fpu_dispatch.sv
// Single-outstanding FP dispatcher: accepts a decoded op, drives the execution
// unit until completion, then writes back one result and accrues fflags.
module fpu_dispatch
  import fpu_dispatch_pkg::*;
#(
  parameter int FPLEN   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [23:0]      req_op,
  input  logic [2:0]       req_rm,
  input  logic [2:0]       frm_csr,
  input  logic [3:0]       req_ctl,
  input  logic             req_rs1_int,
  input  logic [4:0]       req_rd,
  input  logic [31:0]      req_gpr_rs1,
  input  logic [FPLEN-1:0] req_fs1,
  input  logic [FPLEN-1:0] req_fs2,
  input  logic [FPLEN-1:0] req_fs3,
  input  logic             flush,
  output logic             valid_execution,
  output logic [23:0]      sfpu_op,
  output logic [2:0]       fpu_rnd,
  output logic [2:0]       fpu_sel,
  output logic [3:0]       float_control,
  output logic             dec_i0_rs1_en_d,
  output logic [31:0]      gpr_i0_rs1_d,
  output logic [FPLEN-1:0] fs1_data,
  output logic [FPLEN-1:0] fs2_data,
  output logic [FPLEN-1:0] fs3_data,
  input  logic             fpu_complete,
  input  logic             fpu_complete_rd,
  input  logic             IV_exception,
  input  logic [FPLEN-1:0] fpu_result_1,
  input  logic [31:0]      fpu_result_rd,
  input  logic [4:0]       sflags,
  output logic             fpr_we,
  output logic             gpr_we,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_data,
  output logic [4:0]       fflags,
  input  logic             fflags_clr,
  output logic             busy,
  output logic             illegal,
  output logic             timeout_err,
  output logic [1:0]       dbg_state
);

  localparam logic [7:0] L_TO_LAST = 8'(TIMEOUT - 1);

  // Handshake: a request is taken on the cycle req_valid && req_ready; ready is
  // only offered in IDLE outside reset, so one operation is in flight at a time.

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_cnt;
  logic [23:0]      r_op;
  logic [2:0]       r_rm;
  logic [3:0]       r_ctl;
  logic             r_rs1_int;
  logic [4:0]       r_rd;
  logic [31:0]      r_gpr_rs1;
  logic [FPLEN-1:0] r_fs1, r_fs2, r_fs3;
  logic [FPLEN-1:0] r_res1;
  logic [31:0]      r_res_rd;
  logic [4:0]       r_sflags;
  logic             r_iv, r_rd_flag;
  logic [4:0]       r_fflags;
  logic             r_illegal, r_timeout_err;

  logic             w_accept, w_illegal, w_active, w_in_wb, w_complete, w_timeout;
  logic [2:0]       w_rm_res;
  logic [4:0]       w_new_flags;

  fpu_op_check u_check (
    .i_op      (req_op),
    .i_rm      (req_rm),
    .i_frm     (frm_csr),
    .o_rm      (w_rm_res),
    .o_illegal (w_illegal)
  );

  assign req_ready   = (r_state == ST_IDLE) && !rst;
  assign w_accept    = req_valid && req_ready;
  assign w_active    = !rst && ((r_state == ST_ISSUE) || (r_state == ST_WAIT));
  assign w_in_wb     = !rst && (r_state == ST_WB);
  assign w_complete  = w_active && fpu_complete && !flush;
  assign w_timeout   = !rst && (r_state == ST_WAIT) && !fpu_complete && !flush &&
                       (r_cnt == L_TO_LAST);
  assign w_new_flags = r_sflags | {r_iv, 4'b0000};

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept && !w_illegal) w_state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (flush)             w_state_nxt = ST_IDLE;
        else if (fpu_complete) w_state_nxt = ST_WB;
        else                   w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (flush)             w_state_nxt = ST_IDLE;
        else if (fpu_complete) w_state_nxt = ST_WB;
        else if (w_timeout)    w_state_nxt = ST_IDLE;
      end
      ST_WB:    w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                        r_cnt <= 8'd0;
    else if (r_state == ST_ISSUE)   r_cnt <= 8'd0;
    else if (r_state == ST_WAIT)    r_cnt <= r_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op      <= '0;
      r_rm      <= '0;
      r_ctl     <= '0;
      r_rs1_int <= 1'b0;
      r_rd      <= '0;
      r_gpr_rs1 <= '0;
      r_fs1     <= '0;
      r_fs2     <= '0;
      r_fs3     <= '0;
    end else if (w_accept && !w_illegal) begin
      r_op      <= req_op;
      r_rm      <= w_rm_res;
      r_ctl     <= req_ctl;
      r_rs1_int <= req_rs1_int;
      r_rd      <= req_rd;
      r_gpr_rs1 <= req_gpr_rs1;
      r_fs1     <= req_fs1;
      r_fs2     <= req_fs2;
      r_fs3     <= req_fs3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_res1    <= '0;
      r_res_rd  <= '0;
      r_sflags  <= '0;
      r_iv      <= 1'b0;
      r_rd_flag <= 1'b0;
    end else if (w_complete) begin
      r_res1    <= fpu_result_1;
      r_res_rd  <= fpu_result_rd;
      r_sflags  <= sflags;
      r_iv      <= IV_exception;
      r_rd_flag <= fpu_complete_rd;
    end
  end

  // A clear landing on the writeback cycle keeps only this op's flags.
  always_ff @(posedge clk) begin
    if (rst)             r_fflags <= '0;
    else if (fflags_clr) r_fflags <= w_in_wb ? w_new_flags : 5'd0;
    else if (w_in_wb)    r_fflags <= r_fflags | w_new_flags;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_illegal     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_illegal <= w_accept && w_illegal;
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  always_comb begin
    valid_execution = 1'b0;
    sfpu_op         = '0;
    fpu_rnd         = '0;
    fpu_sel         = '0;
    float_control   = '0;
    dec_i0_rs1_en_d = 1'b0;
    gpr_i0_rs1_d    = '0;
    fs1_data        = '0;
    fs2_data        = '0;
    fs3_data        = '0;
    fpr_we          = 1'b0;
    gpr_we          = 1'b0;
    wb_rd           = '0;
    wb_data         = '0;
    if (w_active) begin
      valid_execution = 1'b1;
      sfpu_op         = r_op;
      fpu_rnd         = r_rm;
      fpu_sel         = FPU_SEL_SP;
      float_control   = r_ctl;
      dec_i0_rs1_en_d = r_rs1_int;
      gpr_i0_rs1_d    = r_gpr_rs1;
      fs1_data        = r_fs1;
      fs2_data        = r_fs2;
      fs3_data        = r_fs3;
    end
    if (w_in_wb) begin
      gpr_we  = r_rd_flag;
      fpr_we  = !r_rd_flag;
      wb_rd   = r_rd;
      wb_data = r_rd_flag ? r_res_rd : 32'(r_res1);
    end
  end

  assign busy        = !rst && (r_state != ST_IDLE);
  assign illegal     = r_illegal;
  assign timeout_err = r_timeout_err;
  assign fflags      = r_fflags;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_fpu_dispatch.sv
// Bench for fpu_dispatch: directed and random ops, expected writebacks and
// illegal pulses queued by the driver and checked by an independent monitor.
module tb_fpu_dispatch;

  localparam int EW = 39;  // {kind[1:0], rd[4:0], data[31:0]}
  localparam logic [1:0] K_FPR = 2'd1, K_GPR = 2'd2, K_ILL = 2'd3;

  logic        clk, rst, req_valid, req_ready;
  logic [23:0] req_op;
  logic [2:0]  req_rm, frm_csr;
  logic [3:0]  req_ctl;
  logic        req_rs1_int;
  logic [4:0]  req_rd;
  logic [31:0] req_gpr_rs1, req_fs1, req_fs2, req_fs3;
  logic        flush, valid_execution;
  logic [23:0] sfpu_op;
  logic [2:0]  fpu_rnd, fpu_sel;
  logic [3:0]  float_control;
  logic        dec_i0_rs1_en_d;
  logic [31:0] gpr_i0_rs1_d, fs1_data, fs2_data, fs3_data;
  logic        fpu_complete, fpu_complete_rd, IV_exception;
  logic [31:0] fpu_result_1, fpu_result_rd;
  logic [4:0]  sflags;
  logic        fpr_we, gpr_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  fflags;
  logic        fflags_clr, busy, illegal, timeout_err;
  logic [1:0]  dbg_state;

  logic [EW-1:0] exp_q[$];
  int            n_cmp = 0, n_bad = 0;
  logic [4:0]    exp_fflags = 5'd0;
  logic          exp_to = 1'b0;

  fpu_dispatch #(.FPLEN(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rm(req_rm), .frm_csr(frm_csr), .req_ctl(req_ctl),
    .req_rs1_int(req_rs1_int), .req_rd(req_rd), .req_gpr_rs1(req_gpr_rs1),
    .req_fs1(req_fs1), .req_fs2(req_fs2), .req_fs3(req_fs3), .flush(flush),
    .valid_execution(valid_execution), .sfpu_op(sfpu_op), .fpu_rnd(fpu_rnd),
    .fpu_sel(fpu_sel), .float_control(float_control), .dec_i0_rs1_en_d(dec_i0_rs1_en_d),
    .gpr_i0_rs1_d(gpr_i0_rs1_d), .fs1_data(fs1_data), .fs2_data(fs2_data),
    .fs3_data(fs3_data), .fpu_complete(fpu_complete), .fpu_complete_rd(fpu_complete_rd),
    .IV_exception(IV_exception), .fpu_result_1(fpu_result_1), .fpu_result_rd(fpu_result_rd),
    .sflags(sflags), .fpr_we(fpr_we), .gpr_we(gpr_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .fflags(fflags), .fflags_clr(fflags_clr), .busy(busy), .illegal(illegal),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every writeback or illegal pulse must match the next expectation.
  initial begin
    logic [EW-1:0] act, e;
    forever begin
      @(negedge clk);
      if (fpr_we && gpr_we) check("dual_we", 64'(1), 64'(0));
      if (fpr_we || gpr_we || illegal) begin
        act = {illegal ? K_ILL : (gpr_we ? K_GPR : K_FPR), wb_rd, wb_data};
        if (exp_q.size() == 0) begin
          check("unexpected_event", 64'(act), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("wb_event", 64'(act), 64'(e));
        end
      end
    end
  end

  // mode: 0 complete after delay, 1 never complete, 2 flush (with completion) after delay,
  // 3 reset after delay
  task automatic run_op(input logic [23:0] op, input logic [2:0] rm, input logic [2:0] frm,
                        input logic [4:0] rd, input logic [31:0] f1, input logic [31:0] f2,
                        input logic use_rd, input logic [31:0] res, input logic [4:0] sf,
                        input logic iv, input int delay, input int mode, input logic clr);
    logic [2:0]  rm_res;
    logic        legal;
    logic [3:0]  ctl;
    logic        rs1i;
    logic [31:0] gpr, f3;
    logic [4:0]  nf;
    int          n;
    rm_res = (rm == 3'd7) ? frm : rm;
    legal  = ($countones(op[21:0]) == 1) && !op[3] && !op[4] && rm_res != 3'd5 && rm_res != 3'd6;
    ctl  = 4'($urandom_range(0, 15));
    rs1i = 1'($urandom_range(0, 1));
    gpr  = $urandom;
    f3   = $urandom;
    check("ready_idle", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_op = op; req_rm = rm; frm_csr = frm; req_ctl = ctl;
    req_rs1_int = rs1i; req_rd = rd; req_gpr_rs1 = gpr;
    req_fs1 = f1; req_fs2 = f2; req_fs3 = f3;
    if (!legal) exp_q.push_back({K_ILL, 5'd0, 32'd0});
    step();
    req_valid = 1'b0;
    frm_csr = ~frm;
    if (!legal) begin
      check("ill_no_exec", 64'(valid_execution), 64'(0));
      check("ill_ready", 64'(req_ready), 64'(1));
      check("ill_not_busy", 64'(busy), 64'(0));
      step();
      return;
    end
    check("issue_payload", {fs1_data, fs2_data}, {f1, f2});
    check("issue_ctl", {sfpu_op, float_control, 3'b0, dec_i0_rs1_en_d, fpu_sel, 1'b0, fpu_rnd},
          {op, ctl, 3'b0, rs1i, 3'b001, 1'b0, rm_res});
    check("issue_ops2", {gpr_i0_rs1_d, fs3_data}, {gpr, f3});
    check("issue_busy", 64'({busy, req_ready}), 64'(2'b10));
    if (mode == 1) begin
      n = 0;
      while (!req_ready && n < 40) begin
        step();
        n++;
      end
      exp_to = 1'b1;
      check("timeout_cycles", 64'(n), 64'(17));
      check("timeout_err", 64'(timeout_err), 64'(1));
      check("timeout_fflags", 64'(fflags), 64'(exp_fflags));
      step();
      return;
    end
    for (int k = 0; k < delay; k++) begin
      step();
      check("wait_drive", 64'({valid_execution, fpu_rnd, sfpu_op}), 64'({1'b1, rm_res, op}));
    end
    fpu_complete = 1'b1;
    fpu_complete_rd = use_rd;
    fpu_result_1 = use_rd ? $urandom : res;
    fpu_result_rd = use_rd ? res : $urandom;
    sflags = sf;
    IV_exception = iv;
    if (mode == 2) begin
      flush = 1'b1;
      step();
      flush = 1'b0; fpu_complete = 1'b0;
      check("flush_idle", 64'({req_ready, busy}), 64'(2'b10));
      step();
      check("flush_fflags", 64'(fflags), 64'(exp_fflags));
      return;
    end
    if (mode == 3) begin
      rst = 1'b1;
      step();
      fpu_complete = 1'b0;
      check("rst_cycle", 64'({req_ready, busy, fpr_we, gpr_we, valid_execution}), 64'(0));
      rst = 1'b0;
      exp_fflags = 5'd0;
      exp_to = 1'b0;
      step();
      check("rst_after", 64'({req_ready, busy, fflags, timeout_err}), 64'({2'b10, 5'd0, 1'b0}));
      return;
    end
    nf = sf | {iv, 4'b0};
    exp_q.push_back({use_rd ? K_GPR : K_FPR, rd, res});
    step();
    fpu_complete = 1'b0;
    check("wb_state", 64'({busy, valid_execution, fflags}), 64'({1'b1, 1'b0, exp_fflags}));
    exp_fflags = clr ? nf : (exp_fflags | nf);
    fflags_clr = clr;
    step();
    fflags_clr = 1'b0;
    check("post_wb", 64'({req_ready, busy, fflags, timeout_err}), 64'({2'b10, exp_fflags, exp_to}));
  endtask

  initial begin
    logic [23:0] op;
    int b;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_rm = '0; frm_csr = '0; req_ctl = '0;
    req_rs1_int = 1'b0; req_rd = '0; req_gpr_rs1 = '0; req_fs1 = '0; req_fs2 = '0;
    req_fs3 = '0; flush = 1'b0; fpu_complete = 1'b0; fpu_complete_rd = 1'b0;
    IV_exception = 1'b0; fpu_result_1 = '0; fpu_result_rd = '0; sflags = '0; fflags_clr = 1'b0;
    step();
    step();
    check("reset_outputs", 64'({req_ready, busy, valid_execution, fflags, timeout_err, illegal}), 64'(0));
    rst = 1'b0;
    step();
    check("ready_after_reset", 64'(req_ready), 64'(1));

    // fadd 1.0 + 2.0, then feq returning through the GPR path
    run_op(24'h000001, 3'd0, 3'd0, 5'd5, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000,
           5'd0, 1'b0, 1, 0, 1'b0);
    run_op(24'h004000, 3'd1, 3'd0, 5'd9, $urandom, $urandom, 1'b1, 32'h1, 5'd0, 1'b0, 1, 0, 1'b0);
    // illegal encodings
    run_op(24'h000003, 3'd0, 3'd0, 5'd1, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 1, 0, 1'b0);
    run_op(24'h000008, 3'd0, 3'd0, 5'd1, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 1, 0, 1'b0);
    run_op(24'h000001, 3'd5, 3'd0, 5'd1, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 1, 0, 1'b0);
    run_op(24'h000001, 3'd7, 3'd6, 5'd1, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 1, 0, 1'b0);
    // dynamic rounding, completion in the issue cycle, flush with completion
    run_op(24'h000004, 3'd7, 3'd2, 5'd3, $urandom, $urandom, 1'b0, $urandom, 5'd0, 1'b0, 4, 0, 1'b0);
    run_op(24'h000002, 3'd2, 3'd0, 5'd4, $urandom, $urandom, 1'b0, $urandom, 5'd0, 1'b0, 0, 0, 1'b0);
    run_op(24'h000020, 3'd0, 3'd0, 5'd6, $urandom, $urandom, 1'b0, $urandom, 5'd3, 1'b1, 2, 2, 1'b0);
    run_op(24'h000020, 3'd0, 3'd0, 5'd6, $urandom, $urandom, 1'b0, $urandom, 5'd3, 1'b1, 0, 2, 1'b0);
    // fflags accrual and clear coinciding with writeback
    run_op(24'h000001, 3'd0, 3'd0, 5'd7, $urandom, $urandom, 1'b0, $urandom, 5'b00001, 1'b0, 1, 0, 1'b1);
    run_op(24'h000001, 3'd0, 3'd0, 5'd7, $urandom, $urandom, 1'b0, $urandom, 5'b10000, 1'b0, 1, 0, 1'b0);
    check("fflags_accrue", 64'(fflags), 64'(5'b10001));
    run_op(24'h000001, 3'd0, 3'd0, 5'd7, $urandom, $urandom, 1'b0, $urandom, 5'b10000, 1'b0, 1, 0, 1'b1);
    check("fflags_clr_wb", 64'(fflags), 64'(5'b10000));
    run_op(24'h000400, 3'd3, 3'd0, 5'd8, $urandom, $urandom, 1'b0, $urandom, 5'b00100, 1'b1, 1, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      do b = $urandom_range(0, 21); while (b == 3 || b == 4);
      op = 24'(1) << b;
      op[22] = 1'($urandom_range(0, 1));
      op[23] = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0: op[$urandom_range(0, 21)] = 1'b1;
        1: op[21:0] = 22'd0;
        2: op = 24'(1) << $urandom_range(3, 4);
        default: ;
      endcase
      run_op(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
             $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), $urandom_range(0, 8), ($urandom_range(0, 7) == 0) ? 2 : 0,
             1'($urandom_range(0, 5) == 0));
    end

    // timeout, stickiness across a later op, then reset mid-operation clears it
    run_op(24'h000001, 3'd0, 3'd0, 5'd2, $urandom, $urandom, 1'b0, $urandom, 5'd1, 1'b0, 0, 1, 1'b0);
    run_op(24'h000001, 3'd0, 3'd0, 5'd2, $urandom, $urandom, 1'b0, $urandom, 5'd2, 1'b0, 1, 0, 1'b0);
    check("timeout_sticky", 64'(timeout_err), 64'(1));
    run_op(24'h000002, 3'd0, 3'd0, 5'd2, $urandom, $urandom, 1'b0, $urandom, 5'd2, 1'b0, 2, 3, 1'b0);
    run_op(24'h000001, 3'd0, 3'd0, 5'd11, $urandom, $urandom, 1'b0, $urandom, 5'd4, 1'b0, 1, 0, 1'b0);

    repeat (3) step();
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
